// File: rtl/volume_meter.sv
// Multi-channel volume meter: per-channel windowed mean of |sample| rendered as a thermometer bar.
// Optional peak-hold/decay output when VOLUME_PEAK_HOLD_EN is defined.
module volume_meter #(
    parameter int SAMPLE_W     = 8,
    parameter int LOG2_WINDOW  = 8,
    parameter int CHANNELS     = 2,
    parameter int HOLD_WINDOWS = 4,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SAMPLE_W-1:0]          sample,
    input  logic [CH_W-1:0]              chan,
    input  logic                         start,
    input  logic                         clear,
    output logic                         finish,
    output logic [CHANNELS*SAMPLE_W-1:0] outVolume,
    output logic [CHANNELS*SAMPLE_W-1:0] peakVolume,
    output logic                         vol_valid,
    output logic                         overrun
);

    localparam int SUM_W = SAMPLE_W + LOG2_WINDOW;
    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);
    localparam logic [LOG2_WINDOW-1:0] COUNT_LAST = '1;

    if (CHANNELS < 1 || CHANNELS > 8 || HOLD_WINDOWS < 0) begin : g_bad_params
        $error("volume_meter: unsupported parameter values");
    end

    // Handshake: a start is taken only on a cycle where finish is high; a start
    // seen while finish is low is dropped and latches overrun until reset/clear.
    typedef enum logic [1:0] {IDLE, ACCUM, AVERAGE, UPDATE} state_t;
    state_t state;

    logic [SAMPLE_W-1:0]    lat_sample;
    logic [CH_W-1:0]        lat_ch;
    logic                   lat_ok;
    logic [SAMPLE_W-1:0]    new_bar;
    logic [SUM_W-1:0]       sum_q   [CHANNELS];
    logic [LOG2_WINDOW-1:0] count_q [CHANNELS];
    logic [SAMPLE_W-1:0]    bar_q   [CHANNELS];

    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] avg;
    logic [SAMPLE_W-1:0] bar_calc;
    logic [SUM_W-1:0]    sum_next;

    always_comb begin
        mag      = lat_sample[SAMPLE_W-1] ? (~lat_sample + 1'b1) : lat_sample;
        sum_next = sum_q[lat_ch] + SUM_W'(mag);
        avg      = sum_q[lat_ch][SUM_W-1:LOG2_WINDOW];
        bar_calc = '0;
        // Bar bit p lights when avg has any bit at or above SAMPLE_W-1-p.
        for (int p = 0; p < SAMPLE_W; p++) begin
            bar_calc[p] = |(avg >> (SAMPLE_W - 1 - p));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= IDLE;
            vol_valid  <= 1'b0;
            overrun    <= 1'b0;
            lat_sample <= '0;
            lat_ch     <= '0;
            lat_ok     <= 1'b0;
            new_bar    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c]   <= '0;
                count_q[c] <= '0;
                bar_q[c]   <= '0;
            end
        end else begin
            vol_valid <= 1'b0;
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_sample <= sample;
                        lat_ch     <= chan;
                        lat_ok     <= ({1'b0, chan} < CH_LIMIT);
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (lat_ok) begin
                        sum_q[lat_ch]   <= sum_next;
                        count_q[lat_ch] <= count_q[lat_ch] + 1'b1;
                        state <= (count_q[lat_ch] == COUNT_LAST) ? AVERAGE : IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                AVERAGE: begin
                    new_bar       <= bar_calc;
                    sum_q[lat_ch] <= '0;
                    state         <= UPDATE;
                end
                UPDATE: begin
                    bar_q[lat_ch] <= new_bar;
                    vol_valid     <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign finish = (state == IDLE);

    always_comb begin
        outVolume = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            outVolume[c*SAMPLE_W +: SAMPLE_W] = bar_q[c];
        end
    end

`ifdef VOLUME_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_WINDOWS);

    logic [SAMPLE_W-1:0] peak_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_q [CHANNELS];

    // Peak follows rising bars instantly, then drops one segment per window once hold expires.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
        end else if (state == UPDATE) begin
            if (new_bar >= peak_q[lat_ch]) begin
                peak_q[lat_ch] <= new_bar;
                hold_q[lat_ch] <= HOLD_INIT;
            end else if (hold_q[lat_ch] != '0) begin
                hold_q[lat_ch] <= hold_q[lat_ch] - 1'b1;
            end else begin
                peak_q[lat_ch] <= peak_q[lat_ch] << 1;
            end
        end
    end

    always_comb begin
        peakVolume = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            peakVolume[c*SAMPLE_W +: SAMPLE_W] = peak_q[c];
        end
    end
`else
    assign peakVolume = outVolume;
`endif

endmodule
